// File: rtl/glitch_campaign_sequencer.sv
// Fault-injection campaign sequencer: reset trigger, hold, swept delay, glitch pulse,
// observation window, repeated for a latched number of attempts.
module glitch_campaign_sequencer #(
  parameter int CNT_W      = 16,
  parameter int RESET_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] delay_start,
  input  logic [CNT_W-1:0] delay_step,
  input  logic [CNT_W-1:0] glitch_width,
  input  logic [CNT_W-1:0] window,
  input  logic [CNT_W-1:0] attempts,
  input  logic             target_flag,
  output logic             reset_trigger,
  output logic             glitch,
  output logic             busy,
  output logic             hit,
  output logic             done,
  output logic [CNT_W-1:0] attempt_idx,
  output logic [CNT_W-1:0] cur_delay
);

  // state  | meaning
  // IDLE   | waiting for start
  // RST    | one-cycle reset trigger to the target
  // HOLD   | waiting out the target reset length
  // DELAY  | cur_delay cycles before the glitch
  // GLITCH | glitch driven for glitch_width cycles
  // WINDOW | watching target_flag for window cycles
  // NEXT   | report hit, advance sweep or finish
  typedef enum logic [2:0] {IDLE, RST, HOLD, DELAY, GLITCH, WINDOW, NEXT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LEN = CNT_W'(RESET_HOLD);
  localparam logic [CNT_W-1:0] SAT      = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] step_r, width_r, window_r, attempts_r;
  logic             sticky;
  logic             launch, last, flag_seen;
  logic [CNT_W:0]   delay_sum;

  // Zero-length phases are skipped so they cost no cycles.
  function automatic state_t skip_empty(state_t s, logic [CNT_W-1:0] d,
                                        logic [CNT_W-1:0] w, logic [CNT_W-1:0] win);
    state_t r;
    r = s;
    if (r == HOLD && HOLD_LEN == '0) r = DELAY;
    if (r == DELAY && d == '0)       r = GLITCH;
    if (r == GLITCH && w == '0)      r = WINDOW;
    if (r == WINDOW && win == '0)    r = NEXT;
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(state_t s, logic [CNT_W-1:0] d,
                                                 logic [CNT_W-1:0] w, logic [CNT_W-1:0] win);
    logic [CNT_W-1:0] len;
    case (s)
      HOLD:    len = HOLD_LEN;
      DELAY:   len = d;
      GLITCH:  len = w;
      WINDOW:  len = win;
      default: len = {{(CNT_W-1){1'b0}}, 1'b1};
    endcase
    return len;
  endfunction

  assign launch    = start && !abort;
  assign last      = attempt_idx == attempts_r - 1'b1;
  assign flag_seen = sticky || (state == WINDOW && target_flag);
  assign delay_sum = {1'b0, cur_delay} + {1'b0, step_r};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch && attempts != '0) state_nxt = RST;
      RST:     state_nxt = skip_empty(HOLD, cur_delay, width_r, window_r);
      HOLD:    if (cnt == '0) state_nxt = skip_empty(DELAY, cur_delay, width_r, window_r);
      DELAY:   if (cnt == '0) state_nxt = skip_empty(GLITCH, cur_delay, width_r, window_r);
      GLITCH:  if (cnt == '0) state_nxt = skip_empty(WINDOW, cur_delay, width_r, window_r);
      WINDOW:  if (cnt == '0) state_nxt = NEXT;
      NEXT:    state_nxt = last ? IDLE : RST;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Outputs are registered from the next state so each is high exactly while its phase is current.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      step_r        <= '0;
      width_r       <= '0;
      window_r      <= '0;
      attempts_r    <= '0;
      sticky        <= 1'b0;
      reset_trigger <= 1'b0;
      glitch        <= 1'b0;
      busy          <= 1'b0;
      hit           <= 1'b0;
      done          <= 1'b0;
      attempt_idx   <= '0;
      cur_delay     <= '0;
    end else begin
      state         <= state_nxt;
      reset_trigger <= state_nxt == RST;
      glitch        <= state_nxt == GLITCH;
      busy          <= state_nxt != IDLE;
      hit           <= state_nxt == NEXT && flag_seen;
      done          <= (state_nxt == NEXT && last) ||
                       (state == IDLE && launch && attempts == '0);

      if (state_nxt != state)
        cnt <= phase_len(state_nxt, cur_delay, width_r, window_r) - 1'b1;
      else if (cnt != '0)
        cnt <= cnt - 1'b1;

      if (state_nxt == RST)
        sticky <= 1'b0;
      else if (state == WINDOW && target_flag)
        sticky <= 1'b1;

      if (state == IDLE && launch) begin
        step_r      <= delay_step;
        width_r     <= glitch_width;
        window_r    <= window;
        attempts_r  <= attempts;
        cur_delay   <= delay_start;
        attempt_idx <= '0;
      end

      if (state == NEXT && state_nxt == RST) begin
        attempt_idx <= attempt_idx + 1'b1;
        cur_delay   <= delay_sum[CNT_W] ? SAT : delay_sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_glitch_campaign_sequencer.sv
// Bench for glitch_campaign_sequencer: table vectors, corner sequences and random campaigns
// checked cycle by cycle against an arithmetic timeline model.
module tb_glitch_campaign_sequencer;
  localparam int W = 16;
  localparam int H = 4;

  logic clk = 1'b0;
  logic rst, start, abort, target_flag;
  logic [W-1:0] delay_start, delay_step, glitch_width, window, attempts;
  logic reset_trigger, glitch, busy, hit, done;
  logic [W-1:0] attempt_idx, cur_delay;

  always #5 clk = ~clk;

  glitch_campaign_sequencer #(.CNT_W(W), .RESET_HOLD(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .delay_start(delay_start), .delay_step(delay_step), .glitch_width(glitch_width),
    .window(window), .attempts(attempts), .target_flag(target_flag),
    .reset_trigger(reset_trigger), .glitch(glitch), .busy(busy), .hit(hit), .done(done),
    .attempt_idx(attempt_idx), .cur_delay(cur_delay)
  );

  typedef struct packed {
    logic rt, gl, busy, hit, done;
    logic [W-1:0] idx, cd;
  } obs_t;

  obs_t act;
  assign act = {reset_trigger, glitch, busy, hit, done, attempt_idx, cur_delay};

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] a, input logic [63:0] e);
    n_total++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected outputs on cycle t, start having been high on cycle 0.
  longint m_ds, m_step, m_w, m_win, m_att;
  bit fl [0:2047];

  function automatic obs_t exp_at(int t);
    obs_t e;
    longint s, d, p, g0;
    bit any;
    e = '0;
    e.cd = 16'(m_ds);
    if (m_att == 0) begin
      e.done = (t == 1);
      return e;
    end
    s = 1;
    for (longint a = 0; a < m_att; a++) begin
      d = m_ds + a * m_step;
      if (d > 65535) d = 65535;
      p = 2 + H + d + m_w + m_win;
      e.idx = 16'(a);
      e.cd  = 16'(d);
      if (t < s + p) begin
        g0 = s + 1 + H + d;
        e.busy = 1'b1;
        e.rt   = (t == s);
        e.gl   = (t >= g0 && t < g0 + m_w);
        if (t == s + p - 1) begin
          any = 1'b0;
          for (longint k = g0 + m_w; k < g0 + m_w + m_win; k++)
            if (k < 2048 && fl[int'(k)]) any = 1'b1;
          e.hit  = any;
          e.done = (a == m_att - 1);
        end
        return e;
      end
      s += p;
    end
    return e;
  endfunction

  task automatic start_cfg(input int ds, input int step, input int w, input int win, input int att);
    delay_start  = 16'(ds);
    delay_step   = 16'(step);
    glitch_width = 16'(w);
    window       = 16'(win);
    attempts     = 16'(att);
    start = 1'b1;
    abort = 1'b0;
    target_flag = fl[0];
    tick();
    start = 1'b0;
  endtask

  task automatic run_campaign(input string name, input int ds, input int step, input int w,
                              input int win, input int att, input bit scramble,
                              output int done_at, output int hits, output int glitch0,
                              output int rts, output int last_cd);
    obs_t e;
    int t, idle_run;
    m_ds = ds; m_step = step; m_w = w; m_win = win; m_att = att;
    start_cfg(ds, step, w, win, att);
    done_at = -1; hits = 0; glitch0 = -1; rts = 0;
    t = 1; idle_run = 0;
    while (idle_run < 3 && t < 2000) begin
      e = exp_at(t);
      check(name, 64'(act), 64'(e));
      if (done) done_at = (done_at < 0) ? t : -2;
      if (hit) hits++;
      if (glitch && glitch0 < 0) glitch0 = t;
      if (reset_trigger) rts++;
      idle_run = e.busy ? 0 : idle_run + 1;
      target_flag = fl[t];
      if (scramble) begin
        delay_start  = 16'($urandom);
        delay_step   = 16'($urandom);
        glitch_width = 16'($urandom);
        window       = 16'($urandom);
        attempts     = 16'($urandom);
        start        = e.busy && ($urandom_range(0, 3) == 0);
      end
      tick();
      t++;
    end
    start = 1'b0;
    target_flag = 1'b0;
    check({name, " end"}, 64'(idle_run >= 3), 64'(1));
    last_cd = int'(cur_delay);
  endtask

  typedef struct {
    string name;
    int ds, step, w, win, att, flag_at;
    int exp_done, exp_hits, exp_glitch0, exp_rt, exp_cd;
  } vec_t;

  vec_t vecs [9];

  task automatic run_vec(input vec_t v);
    int d_at, h, g0, r, cd;
    for (int k = 0; k < 2048; k++) fl[k] = 1'b0;
    if (v.flag_at >= 0) fl[v.flag_at] = 1'b1;
    run_campaign(v.name, v.ds, v.step, v.w, v.win, v.att, 1'b1, d_at, h, g0, r, cd);
    check({v.name, " done_cycle"}, 64'(d_at), 64'(v.exp_done));
    check({v.name, " hits"}, 64'(h), 64'(v.exp_hits));
    check({v.name, " first_glitch"}, 64'(g0), 64'(v.exp_glitch0));
    check({v.name, " reset_triggers"}, 64'(r), 64'(v.exp_rt));
    check({v.name, " final_delay"}, 64'(cd), 64'(v.exp_cd));
  endtask

  initial begin
    int d_at, h, g0, r, cd;
    logic any;

    //          name              ds  st w  win att flag done hits g0 rt cd
    vecs[0] = '{"single",          3, 0, 2, 5, 1, -1,  16, 0,  9, 1, 3};
    vecs[1] = '{"sweep",           3, 2, 2, 5, 3, -1,  54, 0,  9, 3, 7};
    vecs[2] = '{"hit_attempt1",    3, 2, 2, 5, 3, 30,  54, 1,  9, 3, 7};
    vecs[3] = '{"flag_in_glitch",  3, 0, 2, 5, 1,  9,  16, 0,  9, 1, 3};
    vecs[4] = '{"zero_attempts",   3, 2, 2, 5, 0, -1,   1, 0, -1, 0, 3};
    vecs[5] = '{"no_glitch",       0, 0, 0, 3, 1, -1,   9, 0, -1, 1, 0};
    vecs[6] = '{"all_zero",        0, 1, 0, 0, 2, -1,  13, 0, -1, 2, 1};
    vecs[7] = '{"window0_flag",    1, 0, 1, 0, 1,  7,   8, 0,  7, 1, 1};
    vecs[8] = '{"flag_last_win",   3, 0, 2, 5, 1, 15,  16, 1,  9, 1, 3};

    for (int k = 0; k < 2048; k++) fl[k] = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; target_flag = 1'b0;
    delay_start = '0; delay_step = '0; glitch_width = '0; window = '0; attempts = '0;
    repeat (3) tick();
    check("reset_state", 64'(act), 64'(0));
    rst = 1'b0;
    tick();
    check("idle_after_reset", 64'(act), 64'(0));

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // abort while the glitch is driven
    start_cfg(3, 2, 2, 5, 3);
    repeat (8) tick();
    check("abort_pre_glitch", 64'(glitch), 64'(1));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_outputs", 64'({glitch, busy, hit, done, reset_trigger}), 64'(0));
    check("abort_hold_idx_delay", 64'({attempt_idx, cur_delay}), 64'({16'd0, 16'd3}));
    any = 1'b0;
    repeat (20) begin
      tick();
      any = any | busy | hit | done | glitch | reset_trigger;
    end
    check("abort_stays_idle", 64'(any), 64'(0));
    run_vec(vecs[1]);

    // start together with abort in IDLE
    delay_start = 16'd3; delay_step = '0; glitch_width = 16'd2; window = 16'd5; attempts = 16'd2;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    any = busy | reset_trigger | done;
    tick();
    any = any | busy | reset_trigger | done;
    check("start_abort_idle", 64'(any), 64'(0));

    // synchronous reset during WINDOW
    start_cfg(3, 0, 2, 5, 1);
    repeat (11) tick();
    check("rst_pre_window_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    check("rst_mid_campaign", 64'(act), 64'(0));
    rst = 1'b0;
    tick();
    check("rst_then_idle", 64'(act), 64'(0));

    for (int n = 0; n < 6; n++) begin
      for (int k = 0; k < 2048; k++) fl[k] = ($urandom_range(0, 3) == 0);
      run_campaign("random", int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   int'($urandom_range(1, 4)), 1'b1, d_at, h, g0, r, cd);
    end

    // delay sweep saturation: attempt 0 NEXT lands on cycle 65542
    for (int k = 0; k < 2048; k++) fl[k] = 1'b0;
    start_cfg(16'hFFFE, 5, 1, 1, 2);
    repeat (65541) tick();
    check("sat_before", 64'({attempt_idx, cur_delay}), 64'({16'd0, 16'hFFFE}));
    tick();
    check("sat_after", 64'({reset_trigger, attempt_idx, cur_delay}), 64'({1'b1, 16'd1, 16'hFFFF}));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("sat_abort_idle", 64'({busy, done, hit}), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
